// File: rtl/ball_engine.sv
// Pong ball-motion engine: advances the ball box once per active frame tick,
// reflects off side walls and both paddles, and sequences serve/miss.
module ball_engine #(
  parameter int W         = 16,
  parameter int BALL      = 15,
  parameter int X_MIN     = 143,
  parameter int X_MAX     = 784,
  parameter int Y_MIN     = 40,
  parameter int Y_MAX     = 515,
  parameter int PAD_TOP_Y = 80,
  parameter int PAD_BOT_Y = 470,
  parameter int X0        = 450,
  parameter int Y0        = 270,
  parameter int MAX_DX    = 3,
  parameter int DY_MIN    = 1,
  parameter int DY_MAX    = 4,
  parameter int SERVE_DLY = 60
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         pause,
  input  logic [W-1:0] left_r1,
  input  logic [W-1:0] right_r1,
  input  logic [W-1:0] left_r2,
  input  logic [W-1:0] right_r2,
  output logic [W-1:0] left,
  output logic [W-1:0] right,
  output logic [W-1:0] top,
  output logic [W-1:0] botton,
  output logic         miss_top,
  output logic         miss_bot,
  output logic         hit,
  output logic         serving
);

  localparam int SW = W + 1;
  localparam int ZW = W + 4;
  localparam int CW = $clog2(SERVE_DLY + 1);

  typedef logic signed [SW-1:0] sc_t;
  typedef logic signed [ZW-1:0] zc_t;
  typedef enum logic {S_SERVE, S_MOVE} state_t;

  localparam sc_t BALL_S  = sc_t'(BALL);
  localparam sc_t X_MIN_S = sc_t'(X_MIN);
  localparam sc_t X_MAX_S = sc_t'(X_MAX);
  localparam sc_t Y_MIN_S = sc_t'(Y_MIN);
  localparam sc_t Y_MAX_S = sc_t'(Y_MAX);
  localparam sc_t PTOP_S  = sc_t'(PAD_TOP_Y);
  localparam sc_t PBOT_S  = sc_t'(PAD_BOT_Y);

  function automatic sc_t ext(input logic [W-1:0] v);
    return $signed({1'b0, v});
  endfunction

  // Horizontal speed from where the ball centre lands on the paddle, in quarters.
  function automatic sc_t zone_dx(input sc_t ball_l, input logic [W-1:0] pad_l,
                                  input logic [W-1:0] pad_r);
    zc_t c, w, c4;
    sc_t res;
    w  = zc_t'(ext(pad_r)) - zc_t'(ext(pad_l));
    c  = zc_t'(ball_l) + zc_t'(BALL / 2) - zc_t'(ext(pad_l));
    if (c < 0) c = '0;
    if (c > w) c = w;
    c4 = c <<< 2;
    if (c4 < w)                    res = -sc_t'(MAX_DX);
    else if (c4 < (w <<< 1))       res = -sc_t'(1);
    else if (c4 < w + (w <<< 1))   res = sc_t'(1);
    else                           res = sc_t'(MAX_DX);
    return res;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  left_q, left_d, top_q, top_d, dy_mag_q, dy_mag_d, dy_mag_up;
  sc_t           dx_q, dx_d;
  logic          dy_dir_q, dy_dir_d;
  logic          hit_q, hit_d, miss_top_q, miss_top_d, miss_bot_q, miss_bot_d;

  sc_t  cur_l, cur_t, cur_r, cur_b, nl, nt, dx_abs;
  logic hit_bot, hit_top, miss_b, miss_t;

  assign cur_l  = ext(left_q);
  assign cur_t  = ext(top_q);
  assign cur_r  = cur_l + BALL_S;
  assign cur_b  = cur_t + BALL_S;
  assign nl     = cur_l + dx_q;
  assign nt     = dy_dir_q ? cur_t + ext(dy_mag_q) : cur_t - ext(dy_mag_q);
  assign dx_abs = dx_q[SW-1] ? -dx_q : dx_q;

  assign hit_bot = dy_dir_q && (cur_b < PBOT_S) && (nt + BALL_S >= PBOT_S) &&
                   (cur_r >= ext(left_r2)) && (cur_l <= ext(right_r2));
  assign hit_top = !dy_dir_q && (cur_t > PTOP_S) && (nt <= PTOP_S) &&
                   (cur_r >= ext(left_r1)) && (cur_l <= ext(right_r1));
  assign miss_b  = (nt + BALL_S > Y_MAX_S);
  assign miss_t  = (nt < Y_MIN_S);

  assign dy_mag_up = (dy_mag_q >= W'(DY_MAX)) ? W'(DY_MAX) : dy_mag_q + W'(1);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    left_d     = left_q;
    top_d      = top_q;
    dx_d       = dx_q;
    dy_dir_d   = dy_dir_q;
    dy_mag_d   = dy_mag_q;
    hit_d      = 1'b0;
    miss_top_d = 1'b0;
    miss_bot_d = 1'b0;

    if (tick && !pause) begin
      case (state_q)
        S_SERVE: begin
          left_d   = W'(X0);
          top_d    = W'(Y0);
          dx_d     = '0;
          dy_mag_d = W'(DY_MIN);
          if (cnt_q == CW'(SERVE_DLY - 1)) begin
            cnt_d   = '0;
            state_d = S_MOVE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          if (nl <= X_MIN_S) begin
            left_d = W'(X_MIN);
            dx_d   = dx_abs;
          end else if (nl + BALL_S >= X_MAX_S) begin
            left_d = W'(X_MAX - BALL);
            dx_d   = -dx_abs;
          end else begin
            left_d = nl[W-1:0];
          end

          // A paddle return sets dx from the hit zone, overriding any wall sign flip.
          if (hit_bot) begin
            top_d    = W'(PAD_BOT_Y - BALL);
            dy_dir_d = 1'b0;
            dy_mag_d = dy_mag_up;
            dx_d     = zone_dx(cur_l, left_r2, right_r2);
            hit_d    = 1'b1;
          end else if (hit_top) begin
            top_d    = W'(PAD_TOP_Y);
            dy_dir_d = 1'b1;
            dy_mag_d = dy_mag_up;
            dx_d     = zone_dx(cur_l, left_r1, right_r1);
            hit_d    = 1'b1;
          end else if (miss_b || miss_t) begin
            state_d    = S_SERVE;
            cnt_d      = '0;
            left_d     = W'(X0);
            top_d      = W'(Y0);
            dx_d       = '0;
            dy_mag_d   = W'(DY_MIN);
            dy_dir_d   = miss_b;
            miss_bot_d = miss_b;
            miss_top_d = !miss_b;
          end else begin
            top_d = nt[W-1:0];
          end
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_SERVE;
      cnt_q      <= '0;
      left_q     <= W'(X0);
      top_q      <= W'(Y0);
      dx_q       <= '0;
      dy_dir_q   <= 1'b1;
      dy_mag_q   <= W'(DY_MIN);
      hit_q      <= 1'b0;
      miss_top_q <= 1'b0;
      miss_bot_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      left_q     <= left_d;
      top_q      <= top_d;
      dx_q       <= dx_d;
      dy_dir_q   <= dy_dir_d;
      dy_mag_q   <= dy_mag_d;
      hit_q      <= hit_d;
      miss_top_q <= miss_top_d;
      miss_bot_q <= miss_bot_d;
    end
  end

  assign left     = left_q;
  assign right    = left_q + W'(BALL);
  assign top      = top_q;
  assign botton   = top_q + W'(BALL);
  assign hit      = hit_q;
  assign miss_top = miss_top_q;
  assign miss_bot = miss_bot_q;
  assign serving  = (state_q == S_SERVE);

endmodule

// File: tb/tb_ball_engine.sv
// Scoreboard bench for ball_engine: directed scenarios push hand-computed
// expectations keyed by active-tick number; a monitor compares them as ticks land.
module tb_ball_engine;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tick = 1'b0;
  logic         pause = 1'b0;
  logic [W-1:0] left_r1 = '0, right_r1 = '0, left_r2 = '0, right_r2 = '0;
  logic [W-1:0] left, right, top, botton;
  logic         miss_top, miss_bot, hit, serving;

  ball_engine dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .pause    (pause),
    .left_r1  (left_r1),
    .right_r1 (right_r1),
    .left_r2  (left_r2),
    .right_r2 (right_r2),
    .left     (left),
    .right    (right),
    .top      (top),
    .botton   (botton),
    .miss_top (miss_top),
    .miss_bot (miss_bot),
    .hit      (hit),
    .serving  (serving)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    seq;
    string name;
    int    left;
    int    top;
    int    hit;
    int    mtop;
    int    mbot;
    int    serving;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks_n = 0;
  int   errors_n = 0;
  int   act_n = 0;
  logic [2:0] prev_p = '0;

  task automatic check(input string name, input int act, input int exp);
    checks_n++;
    if (act != exp) begin
      errors_n++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_at(input int seq, input string name, input int l, input int t,
                           input int h, input int mt, input int mb, input int s);
    exp_t x;
    x.seq = seq; x.name = name; x.left = l; x.top = t;
    x.hit = h; x.mtop = mt; x.mbot = mb; x.serving = s;
    sb.push_back(x);
  endtask

  // Monitor: every active tick is a DUT output event; compare the matching entry.
  always @(posedge clk) begin
    if (rst) begin
      act_n = 0;
    end else if (tick && !pause) begin
      act_n++;
      #1;
      while (sb.size() > 0 && sb[0].seq < act_n) begin
        e = sb.pop_front();
        check({e.name, "_skipped"}, act_n, e.seq);
      end
      if (sb.size() > 0 && sb[0].seq == act_n) begin
        e = sb.pop_front();
        check({e.name, "_left"},    int'(left),     e.left);
        check({e.name, "_top"},     int'(top),      e.top);
        check({e.name, "_hit"},     int'(hit),      e.hit);
        check({e.name, "_mtop"},    int'(miss_top), e.mtop);
        check({e.name, "_mbot"},    int'(miss_bot), e.mbot);
        check({e.name, "_serving"}, int'(serving),  e.serving);
      end
    end
  end

  // Per-cycle invariants: box geometry, wall bound, pulse exclusivity and width.
  always @(negedge clk) begin
    logic [2:0] p;
    p = {hit, miss_top, miss_bot};
    check("right_box",    int'(right), int'(left) + 15);
    check("botton_box",   int'(botton), int'(top) + 15);
    check("left_min",     int'(left >= 16'd143), 1);
    check("pulse_onehot", int'($countones(p) <= 1), 1);
    check("pulse_width",  int'(|(p & prev_p)), 0);
    prev_p = p;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached with %0d entries pending", sb.size());
    $fatal(1, "watchdog");
  end

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
    end
  endtask

  task automatic set_pads(input logic [W-1:0] l1, input logic [W-1:0] r1,
                          input logic [W-1:0] l2, input logic [W-1:0] r2);
    left_r1 = l1; right_r1 = r1; left_r2 = l2; right_r2 = r2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_left"},    int'(left),     450);
    check({tag, "_right"},   int'(right),    465);
    check({tag, "_top"},     int'(top),      270);
    check({tag, "_botton"},  int'(botton),   285);
    check({tag, "_serving"}, int'(serving),  1);
    check({tag, "_hit"},     int'(hit),      0);
    check({tag, "_mtop"},    int'(miss_top), 0);
    check({tag, "_mbot"},    int'(miss_bot), 0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1 check_reset_outputs("reset");
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      check("drain_pending", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    // Serve timing, centre-left bottom return, top miss, serve heading up.
    set_pads(16'd0, 16'd0, 16'd400, 16'd520);
    do_reset();
    expect_at( 59, "serve_hold",  450, 270, 0, 0, 0, 1);
    expect_at( 60, "serve_exit",  450, 270, 0, 0, 0, 0);
    expect_at( 61, "first_move",  450, 271, 0, 0, 0, 0);
    expect_at(244, "pre_hit",     450, 454, 0, 0, 0, 0);
    expect_at(245, "bot_hit",     450, 455, 1, 0, 0, 0);
    expect_at(246, "after_hit",   449, 453, 0, 0, 0, 0);
    expect_at(452, "pre_mtop",    243,  41, 0, 0, 0, 0);
    expect_at(453, "miss_top",    450, 270, 0, 1, 0, 1);
    expect_at(454, "reserve",     450, 270, 0, 0, 0, 1);
    expect_at(513, "serve_exit2", 450, 270, 0, 0, 0, 0);
    expect_at(514, "serve_up",    450, 269, 0, 0, 0, 0);
    run_ticks(514);
    drain();

    // Bottom miss, then asynchronous reset while the miss pulse is high.
    set_pads(16'd0, 16'd0, 16'd0, 16'd100);
    do_reset();
    expect_at(290, "pre_mbot", 450, 500, 0, 0, 0, 0);
    expect_at(291, "miss_bot", 450, 270, 0, 0, 1, 1);
    run_ticks(290);
    @(negedge clk); tick = 1'b1;
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_outputs("async_pulse");
    @(negedge clk); tick = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    drain();

    // Left-edge return at -3, wall clamp to 143, then a top-paddle return.
    set_pads(16'd380, 16'd500, 16'd455, 16'd575);
    do_reset();
    expect_at(245, "edge_hit",  450, 455, 1, 0, 0, 0);
    expect_at(346, "wall_m2",   147, 253, 0, 0, 0, 0);
    expect_at(347, "wall_m1",   144, 251, 0, 0, 0, 0);
    expect_at(348, "wall_clamp",143, 249, 0, 0, 0, 0);
    expect_at(349, "wall_out",  146, 247, 0, 0, 0, 0);
    expect_at(432, "pre_thit",  395,  81, 0, 0, 0, 0);
    expect_at(433, "top_hit",   398,  80, 1, 0, 0, 0);
    expect_at(434, "after_thit",395,  83, 0, 0, 0, 0);
    run_ticks(434);
    drain();

    // Pause during serve and mid-flight, then asynchronous reset mid-flight.
    set_pads(16'd0, 16'd0, 16'd0, 16'd100);
    do_reset();
    expect_at(30, "pre_pause",  450, 270, 0, 0, 0, 1);
    expect_at(59, "p_serve",    450, 270, 0, 0, 0, 1);
    expect_at(60, "p_exit",     450, 270, 0, 0, 0, 0);
    expect_at(61, "p_move",     450, 271, 0, 0, 0, 0);
    expect_at(70, "p_flight",   450, 280, 0, 0, 0, 0);
    expect_at(71, "p_resume",   450, 281, 0, 0, 0, 0);
    expect_at(75, "p_resume5",  450, 285, 0, 0, 0, 0);
    run_ticks(30);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      check("pause_srv_serving", int'(serving), 1);
      check("pause_srv_top",     int'(top),     270);
    end
    pause = 1'b0;
    run_ticks(40);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      check("pause_top",     int'(top),     280);
      check("pause_left",    int'(left),    450);
      check("pause_serving", int'(serving), 0);
      check("pause_pulses",  int'(hit | miss_top | miss_bot), 0);
    end
    pause = 1'b0;
    run_ticks(5);
    drain();
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_outputs("async_flight");
    @(negedge clk);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end

endmodule
